// File: rtl/score_stream_reader.sv
// Streams a completed 4x4 FP32 score file out over valid/ready, one entry at
// a time, tracking the per-row maximum under the FP32 total order.
module score_stream_reader (
   input  logic        clk,
   input  logic        rst,
   input  logic        score_done,
   output logic [3:0]  score_rd_addr,
   output logic        score_rd_en,
   input  logic [31:0] score_rd_data,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:0]  out_row,
   output logic [1:0]  out_col,
   output logic        out_last,
   output logic [31:0] row_max,
   output logic        row_max_valid,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      SEND,
      NEXT
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  k;
   logic [31:0] run_max;
   logic        new_max;

   // Unsigned compare of these keys gives the FP32 total order (-NaN < -inf
   // < ... < -0 < +0 < ... < +inf < +NaN).
   function automatic logic [31:0] order_key(input logic [31:0] b);
      return b[31] ? ~b : {1'b1, b[30:0]};
   endfunction

   assign new_max = order_key(score_rd_data) > order_key(run_max);

   assign score_rd_en   = (state == ISSUE);
   assign score_rd_addr = k;
   assign busy          = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (score_done) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    state_nxt = SEND;
         SEND:    if (out_ready) state_nxt = NEXT;
         NEXT:    state_nxt = (k == 4'd15) ? IDLE : ISSUE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         k             <= '0;
         run_max       <= '0;
         out_data      <= '0;
         out_valid     <= 1'b0;
         out_row       <= '0;
         out_col       <= '0;
         out_last      <= 1'b0;
         row_max       <= '0;
         row_max_valid <= 1'b0;
         done          <= 1'b0;
      end else begin
         row_max_valid <= 1'b0;
         done          <= 1'b0;
         case (state)
            IDLE: begin
               if (score_done) k <= '0;
            end
            WAIT: begin
               out_data  <= score_rd_data;
               out_row   <= k[3:2];
               out_col   <= k[1:0];
               out_last  <= &k[1:0];
               out_valid <= 1'b1;
               if (k[1:0] == 2'd0 || new_max) run_max <= score_rd_data;
            end
            SEND: begin
               // Pulses land in the NEXT cycle that follows the handshake.
               if (out_ready) begin
                  out_valid     <= 1'b0;
                  row_max_valid <= out_last;
                  done          <= (k == 4'd15);
                  if (out_last) row_max <= run_max;
               end
            end
            NEXT: begin
               if (k != 4'd15) k <= k + 4'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/score_stream_reader.md
SCORE_STREAM_READER -- requirements
Module: score_stream_reader

Interface
REQ-001 clk  input  1  rising-edge clock; sole clock.
REQ-002 rst  input  1  reset: synchronous, active-low; sampled on rising clk edge.
REQ-003 score_done  input  1  one-cycle pulse from the score calculator; the 4x4 score register file is complete.
REQ-004 score_rd_addr  output  4  score entry index = 4*row + col.
REQ-005 score_rd_en  output  1  read strobe to the score register file.
REQ-006 score_rd_data  input  32  FP32 score; registered by the responder, valid the cycle after score_rd_en.
REQ-007 out_data  output  32  streamed FP32 score.
REQ-008 out_valid  output  1  out_data/out_row/out_col/out_last valid.
REQ-009 out_ready  input  1  downstream accept.
REQ-010 out_row, out_col  output  2 each  matrix position of out_data.
REQ-011 out_last  output  1  high when out_col==3 (last score of a row).
REQ-012 row_max  output  32  FP32 maximum of the most recently completed row.
REQ-013 row_max_valid  output  1  one-cycle pulse: row_max updated.
REQ-014 busy  output  1  high from the accepted start through the final handshake.
REQ-015 done  output  1  one-cycle pulse after the 16th handshake.

Function
REQ-016 States SHALL be IDLE, ISSUE, WAIT, SEND, NEXT.
REQ-017 IDLE: busy=0. On score_done=1, the block SHALL clear entry counter k=0, set busy=1 and go to ISSUE.
REQ-018 ISSUE: the block SHALL drive score_rd_en=1 and score_rd_addr=k for exactly one cycle, then go to WAIT.
REQ-019 WAIT: the block SHALL register out_data<=score_rd_data, out_row<=k[3:2], out_col<=k[1:0], out_last<=(k[1:0]==3), set out_valid=1 and go to SEND.
REQ-020 WAIT also updates the running max: if k[1:0]==0, run_max<=score_rd_data; otherwise run_max<=fpmax(run_max, score_rd_data).
REQ-021 fpmax SHALL use an FP32 total order key: sign=0 -> {1,bits[30:0]}; sign=1 -> ~bits (all 32 bits). The larger key wins; ties keep run_max.
REQ-022 Consequences of REQ-021: -0 < +0; +NaN patterns exceed +inf; -NaN patterns are below -inf.
REQ-023 SEND: out_valid, out_data, out_row, out_col and out_last SHALL stay stable until out_valid&&out_ready. On that edge out_valid<=0 and the state goes to NEXT.
REQ-024 NEXT, when out_last of the sent entry was 1: row_max<=run_max and row_max_valid=1 for that one cycle.
REQ-025 NEXT, when k==15: busy<=0, done=1 for one cycle, go to IDLE. Otherwise k<=k+1 and go to ISSUE.
REQ-026 Minimum per-entry period is 4 cycles (ISSUE, WAIT, SEND with out_ready=1, NEXT).
REQ-027 score_rd_en SHALL be 0 outside ISSUE. score_rd_addr SHALL hold its last value when idle.
REQ-028 score_done while busy=1 SHALL be ignored; it is not queued.
REQ-029 out_ready while out_valid=0 SHALL have no effect.
REQ-030 k SHALL be 4 bits and SHALL NOT wrap inside a run; the run ends at k==15.
REQ-031 row_max SHALL hold its value between pulses and across runs until overwritten.
REQ-032 done and row_max_valid SHALL both pulse in the NEXT cycle of entry 15.

Reset
REQ-033 With rst=0 at a clk edge, the block SHALL enter IDLE with k=0, run_max=0, and all outputs 0: score_rd_addr, score_rd_en, out_data, out_valid, out_row, out_col, out_last, row_max, row_max_valid, busy, done.
REQ-034 Reset mid-run SHALL abort the run and drop out_valid without a handshake. A later score_done SHALL start a new run from k=0.

Verification
REQ-035 Scores with entry n = FP32 of n (0.0..15.0), score_done pulse, out_ready=1 -> 16 outputs in address order with period 4. row_max is 3.0, 7.0, 11.0, 15.0 at the four row_max_valid pulses. done is coincident with the 4th pulse, 64 cycles after start.
REQ-036 Row 0 = {0xBF800000(-1.0), 0x80000000(-0), 0x00000000(+0), 0xC0000000(-2.0)} -> row_max = 0x00000000. Row 1 all 0xC1200000 (-10.0) -> row_max = 0xC1200000.
REQ-037 out_ready held 0 for 5 cycles on entry 6 -> out_data/out_row=1/out_col=2 stable, no new score_rd_en; the stream resumes the cycle after out_ready=1.
REQ-038 score_done re-pulsed at entry 8 -> ignored; exactly 16 outputs and one done.
REQ-039 rst=0 during SEND of entry 9 -> the next cycle has all outputs 0 and IDLE. A new score_done restarts with score_rd_addr=0 and emits 16 entries.
REQ-040 +inf (0x7F800000) and 0x7FC00000 in row 2 -> row_max = 0x7FC00000.
